// File: rtl/ffstdp_sweep_ctrl_pkg.sv
// Shared definitions for the FF-STDP training sweep controller.
// This file holds the FSM state encoding, the fixed write-back latency and
// the synapse address mapping used by the read and write sides.
package ffstdp_sweep_ctrl_pkg;

    // Sweep controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    // Read-issue to write-back distance: one SRAM read cycle plus one datapath register
    localparam int PIPE_LAT = 2;

    // Row-major synapse address: each presynaptic row holds n_post consecutive weights
    function automatic int compose_addr(input int pre, input int post, input int n_post);
        return pre * n_post + post;
    endfunction

endpackage

// File: rtl/ffstdp_wb_pipe.sv
// Write-back delay line for the weight sweep.
// Every issued read travels DEPTH stages as a {valid, addr} pair and emerges as
// the matching write. Bubbles (stall cycles) travel through as non-writes.
module ffstdp_wb_pipe
    import ffstdp_sweep_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  pending
);

    logic [DEPTH-1:0]      valid_sr;
    logic [ADDR_WIDTH-1:0] addr_sr [DEPTH];

    // Shift the valid bits and addresses one stage every cycle; reset drops in-flight writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_sr[i] <= '0;
            end
        end else begin
            valid_sr <= {valid_sr[DEPTH-2:0], in_valid};
            addr_sr[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_addr  = addr_sr[DEPTH-1];
    // Any live entry short of the last stage means more writes follow the current cycle
    assign pending   = |valid_sr[DEPTH-2:0];

endmodule

// File: rtl/ffstdp_sweep_ctrl.sv
// Training-phase scheduler for the FF-STDP weight update.
// On an accepted START it walks every synapse (pre outer, post inner), issuing
// one weight read per granted cycle; each weight is written back PIPE_LAT
// cycles after its read. The read port is yielded whenever SRAM_GNT is low.
module ffstdp_sweep_ctrl
    import ffstdp_sweep_ctrl_pkg::*;
#(
    parameter int N_PRE          = 256,
    parameter int N_POST         = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int PRE_IDX_WIDTH  = 8,
    parameter int POST_IDX_WIDTH = 4
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      START,
    input  logic                      IS_POS_IN,
    input  logic                      IS_TRAIN_IN,
    input  logic                      SRAM_GNT,
    output logic                      SRAM_RE,
    output logic [ADDR_WIDTH-1:0]     SRAM_RADDR,
    output logic [PRE_IDX_WIDTH-1:0]  PRE_IDX,
    output logic [POST_IDX_WIDTH-1:0] POST_IDX,
    output logic                      SRAM_WE,
    output logic [ADDR_WIDTH-1:0]     SRAM_WADDR,
    output logic                      CTRL_TREF_EVENT,
    output logic                      IS_POS,
    output logic                      IS_TRAIN,
    output logic                      BUSY,
    output logic                      DONE
);

    logic [1:0]                state;
    logic [1:0]                state_next;
    logic [PRE_IDX_WIDTH-1:0]  pre_idx;
    logic [POST_IDX_WIDTH-1:0] post_idx;
    logic                      is_pos_q;
    logic                      is_train_q;
    logic                      start_ok;
    logic                      read_fire;
    logic                      last_pre;
    logic                      last_post;
    logic                      last_read;
    logic                      pipe_pending;
    logic                      wb_valid;
    logic [ADDR_WIDTH-1:0]     wb_addr;

    assign start_ok  = (state == ST_IDLE) && START;
    assign read_fire = (state == ST_RUN) && SRAM_GNT;
    assign last_pre  = (pre_idx == PRE_IDX_WIDTH'(N_PRE - 1));
    assign last_post = (post_idx == POST_IDX_WIDTH'(N_POST - 1));
    assign last_read = read_fire && last_pre && last_post;

    // Next-state logic; a non-training START passes through an empty DRAIN so DONE lands two cycles later
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_next = IS_TRAIN_IN ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                if (last_read) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No new reads here, so the pipe is empty after this edge once only the last stage is live
                if (!pipe_pending) begin
                    state_next = ST_FIN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Synapse walk: post advances on every granted read and carries into pre on wrap
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pre_idx  <= '0;
            post_idx <= '0;
        end else if (start_ok) begin
            pre_idx  <= '0;
            post_idx <= '0;
        end else if (read_fire) begin
            if (last_post) begin
                post_idx <= '0;
                pre_idx  <= last_pre ? '0 : pre_idx + 1'b1;
            end else begin
                post_idx <= post_idx + 1'b1;
            end
        end
    end

    // Sample label and training enable are frozen at START and held until the next accepted START
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            is_pos_q   <= 1'b0;
            is_train_q <= 1'b0;
        end else if (start_ok) begin
            is_pos_q   <= IS_POS_IN;
            is_train_q <= IS_TRAIN_IN;
        end
    end

    ffstdp_wb_pipe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (PIPE_LAT)
    ) u_wb_pipe (
        .clk       (CLK),
        .rst_n     (RSTN),
        .in_valid  (read_fire),
        .in_addr   (SRAM_RADDR),
        .out_valid (wb_valid),
        .out_addr  (wb_addr),
        .pending   (pipe_pending)
    );

    assign SRAM_RE         = read_fire;
    assign SRAM_RADDR      = ADDR_WIDTH'(compose_addr(32'(pre_idx), 32'(post_idx), N_POST));
    assign PRE_IDX         = pre_idx;
    assign POST_IDX        = post_idx;
    assign SRAM_WE         = wb_valid;
    assign SRAM_WADDR      = wb_addr;
    assign CTRL_TREF_EVENT = wb_valid;
    assign IS_POS          = is_pos_q;
    assign IS_TRAIN        = is_train_q;
    assign BUSY            = (state == ST_RUN) || (state == ST_DRAIN);
    assign DONE            = (state == ST_FIN);

endmodule
